// File: rtl/imem_loader.sv
// Packs class-coded instruction fields into MIPS words and streams them into
// instruction memory, holding the core in reset until the program is loaded.
module imem_loader #(
  parameter int AW       = 6,
  parameter int MAXWORDS = 2 ** AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_class,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          imem_we,
  output logic [AW-1:0] imem_wa,
  output logic [31:0]   imem_wd,
  output logic          cpu_reset,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count
);

  localparam logic [2:0] CLS_RTYPE = 3'd0;
  localparam logic [2:0] CLS_LW    = 3'd1;
  localparam logic [2:0] CLS_SW    = 3'd2;
  localparam logic [2:0] CLS_BEQ   = 3'd3;
  localparam logic [2:0] CLS_ADDI  = 3'd4;
  localparam logic [2:0] CLS_J     = 3'd5;
  localparam logic [2:0] CLS_END   = 3'd6;

  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAXWORDS);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t        state_q;
  logic          in_ready_q;
  logic          imem_we_q;
  logic [AW-1:0] imem_wa_q;
  logic [31:0]   imem_wd_q;
  logic          cpu_reset_q;
  logic          done_q;
  logic          err_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_inc;
  logic [31:0]   enc_d;
  logic          accept;

  assign accept    = in_valid && in_ready_q;
  assign count_inc = count_q + CNT_ONE;

  // Opcodes/functs match what the core's main and ALU decoders expect.
  always_comb begin
    enc_d = '0;
    case (in_class)
      CLS_RTYPE: enc_d = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
      CLS_LW:    enc_d = {6'b100011, in_rs, in_rt, in_imm};
      CLS_SW:    enc_d = {6'b101011, in_rs, in_rt, in_imm};
      CLS_BEQ:   enc_d = {6'b000100, in_rs, in_rt, in_imm};
      CLS_ADDI:  enc_d = {6'b001000, in_rs, in_rt, in_imm};
      CLS_J:     enc_d = {6'b000010, in_target};
      default:   enc_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      imem_wa_q   <= '0;
      imem_wd_q   <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (in_class == CLS_END) begin
              state_q     <= ST_DONE;
              in_ready_q  <= 1'b0;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else if (in_class == 3'd7) begin
              state_q    <= ST_ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              imem_we_q <= 1'b1;
              imem_wa_q <= count_q[AW-1:0];
              imem_wd_q <= enc_d;
              count_q   <= count_inc;
              // The word that fills memory also releases the core.
              if (count_inc == MAX_CNT) begin
                state_q     <= ST_DONE;
                in_ready_q  <= 1'b0;
                done_q      <= 1'b1;
                cpu_reset_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          if (start) begin
            state_q     <= ST_LOAD;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign imem_we   = imem_we_q;
  assign imem_wa   = imem_wa_q;
  assign imem_wd   = imem_wd_q;
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a full-size and a 4-word instance share stimulus and
// are both compared every cycle against a behavioural loader model.
module tb_imem_loader;
  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_class = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  logic [1:0]    rdy, we, cpr, dn, er;
  logic [AW-1:0] wa  [2];
  logic [31:0]   wd  [2];
  logic [AW:0]   cnt [2];

  always #5 clk = ~clk;

  imem_loader #(.AW(AW), .MAXWORDS(64)) u_big (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy[0]), .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(we[0]), .imem_wa(wa[0]), .imem_wd(wd[0]), .cpu_reset(cpr[0]),
    .done(dn[0]), .err(er[0]), .count(cnt[0])
  );

  imem_loader #(.AW(AW), .MAXWORDS(4)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_ready(rdy[1]), .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .imem_we(we[1]), .imem_wa(wa[1]), .imem_wd(wd[1]), .cpu_reset(cpr[1]),
    .done(dn[1]), .err(er[1]), .count(cnt[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one slot per instance
  int          m_max [2] = '{64, 4};
  bit          m_load[2], m_done[2], m_err[2], m_cpr[2], m_acc[2], m_we[2], m_rst[2];
  int          m_cnt [2];
  int          m_wa  [2];
  logic [31:0] m_wd  [2];
  logic [31:0] mem0  [64];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
  endtask

  function automatic logic [31:0] encode(input logic [2:0] cls);
    logic [31:0] op;
    logic [31:0] regs;
    op   = 32'd0;
    regs = 32'(in_rs) * 32'h0020_0000 + 32'(in_rt) * 32'h0001_0000;
    case (cls)
      3'd0: return regs + 32'(in_rd) * 32'h0000_0800 + 32'(in_funct);
      3'd1: op = 32'd35;
      3'd2: op = 32'd43;
      3'd3: op = 32'd4;
      3'd4: op = 32'd8;
      3'd5: return 32'd2 * 32'h0400_0000 + 32'(in_target);
      default: return 32'd0;
    endcase
    return op * 32'h0400_0000 + regs + 32'(in_imm);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 1'b0;
      m_we[d]  = 1'b0;
      m_rst[d] = 1'b0;
      if (!reset_n) begin
        m_load[d] = 1'b0; m_done[d] = 1'b0; m_err[d] = 1'b0;
        m_cpr[d]  = 1'b1; m_cnt[d]  = 0;    m_rst[d] = 1'b1;
      end else if (!m_load[d]) begin
        if (start) begin
          m_load[d] = 1'b1; m_cnt[d] = 0; m_done[d] = 1'b0;
          m_err[d]  = 1'b0; m_cpr[d] = 1'b1;
        end
      end else if (in_valid && m_cnt[d] < m_max[d]) begin
        m_acc[d] = 1'b1;
        if (in_class == 3'd6) begin
          m_load[d] = 1'b0; m_done[d] = 1'b1; m_cpr[d] = 1'b0;
        end else if (in_class == 3'd7) begin
          m_load[d] = 1'b0; m_err[d] = 1'b1;
        end else begin
          m_we[d] = 1'b1;
          m_wa[d] = m_cnt[d];
          m_wd[d] = encode(in_class);
          m_cnt[d]++;
          if (m_cnt[d] == m_max[d]) begin
            m_load[d] = 1'b0; m_done[d] = 1'b1; m_cpr[d] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk("in_ready", d, rdy[d], (m_load[d] && m_cnt[d] < m_max[d]));
      chk("imem_we", d, we[d], m_we[d]);
      chk("cpu_reset", d, cpr[d], m_cpr[d]);
      chk("done", d, dn[d], m_done[d]);
      chk("err", d, er[d], m_err[d]);
      chk("count", d, cnt[d], m_cnt[d]);
      if (m_we[d]) begin
        chk("imem_wa", d, wa[d], m_wa[d]);
        chk("imem_wd", d, wd[d], m_wd[d]);
        $display("wr dut%0d addr=%0d data=%08h", d, wa[d], wd[d]);
      end
      if (m_rst[d]) begin
        chk("rst_wa", d, wa[d], 0);
        chk("rst_wd", d, wd[d], 0);
      end
    end
    if (we[0]) mem0[wa[0]] = wd[0];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                      input logic [25:0] tgt, input bit bubbles);
    int k;
    in_class = cls; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = fn; in_imm = imm; in_target = tgt;
    k = 0;
    do begin
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      k++;
    end while (!m_acc[0] && k < 40);
    chk("accept_timeout", 0, rdy[0] | m_acc[0], 1);
    $display("txn class=%0d after %0d cycles", cls, k);
  endtask

  task automatic rand_word(input bit bubbles);
    send(3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom),
         6'($urandom), 16'($urandom), 26'($urandom), bubbles);
  endtask

  logic [31:0] sweep_exp [6] = '{32'h00221820, 32'h8C080004, 32'hAC080008,
                                 32'h1109FFFF, 32'h20020005, 32'h08000010};

  initial begin
    // Reset and idle
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    idle(3);

    // Encoding sweep, back-to-back
    pulse_start();
    send(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0, 26'h0, 1'b0);
    send(3'd1, 5'd0, 5'd8, 5'd0, 6'h0, 16'd4, 26'h0, 1'b0);
    send(3'd2, 5'd0, 5'd8, 5'd0, 6'h0, 16'd8, 26'h0, 1'b0);
    send(3'd3, 5'd8, 5'd9, 5'd0, 6'h0, 16'hFFFF, 26'h0, 1'b0);
    send(3'd4, 5'd0, 5'd2, 5'd0, 6'h0, 16'd5, 26'h0, 1'b0);
    send(3'd5, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0000010, 1'b0);
    send(3'd6, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    chk("end_done", 0, dn[0], 1);
    chk("end_cpu_reset", 0, cpr[0], 0);
    idle(2);
    for (int i = 0; i < 6; i++) chk("sweep_word", 0, mem0[i], sweep_exp[i]);

    // Randomised stream with bubbles
    pulse_start();
    for (int i = 0; i < 20; i++) rand_word(1'b1);
    send(3'd6, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b1);
    idle(2);

    // Fill the 4-word instance with 5 ADDI words
    pulse_start();
    in_class = 3'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_imm = 16'(i + 1);
      cycle();
    end
    chk("full_count", 1, cnt[1], 4);
    chk("full_done", 1, dn[1], 1);
    chk("full_ready", 1, rdy[1], 0);
    idle(2);

    // Illegal class after two words, then restart
    pulse_start();
    rand_word(1'b0);
    rand_word(1'b0);
    send(3'd7, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    in_valid = 1'b0;
    chk("illegal_err", 0, er[0], 1);
    chk("illegal_cpu_reset", 0, cpr[0], 1);
    idle(2);
    pulse_start();
    chk("restart_err", 0, er[0], 0);
    chk("restart_count", 0, cnt[0], 0);
    rand_word(1'b0);
    chk("restart_addr", 0, wa[0], 0);
    idle(1);

    // Reset mid-session, then reload from address 0
    pulse_start();
    for (int i = 0; i < 3; i++) rand_word(1'b0);
    in_valid = 1'b0;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("midrst_count", 0, cnt[0], 0);
    chk("midrst_cpu_reset", 0, cpr[0], 1);
    idle(2);
    pulse_start();
    rand_word(1'b0);
    chk("reload_addr", 0, wa[0], 0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
